// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: opcode and FSM state encodings,
// plus the legal-opcode check used by the result decode.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_NOT = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_ASR = 4'd8,
        OP_MUL = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [3:0] OP_LAST = 4'd9;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial-product step per clock, WIDTH steps.
// done pulses combinationally during the last step; product is valid with it.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 hz100,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic                 busy_q, busy_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   step;

    // acc holds {partial sum, remaining multiplier bits}; each step adds the
    // multiplicand when the current LSB is set, then shifts right by one.
    always_comb begin
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        step    = {sum, acc_q[WIDTH-1:1]};
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        done    = 1'b0;
        if (start) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            mcand_d = a;
            acc_d   = {{WIDTH{1'b0}}, b};
        end else if (busy_q) begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                done   = 1'b1;
                busy_d = 1'b0;
            end
        end
        product = step;
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready on both sides; single-cycle ops
// complete on the accept edge, MUL runs through the shift-add sub-block.
//
// state | meaning
// IDLE  | may accept an op; single-cycle results load directly from here
// MUL   | multiplier stepping, input side stalled
// HOLD  | MUL result presented, waiting for out_ready before accepting again
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] m_hi,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     m_hi_q, m_hi_d;
    flags_t               flags_q, flags_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    logic [WIDTH-1:0]     alu_m;
    logic                 alu_c, alu_v, alu_err;
    logic [SHW-1:0]       sh;
    logic [WIDTH:0]       sum, diff, shl, shr;
    logic signed [WIDTH:0] asr;

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .hz100   (hz100),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Shifts run one bit wider than the operand so the extra bit catches the
    // last bit shifted out, which becomes the carry flag (zero when sh == 0).
    always_comb begin
        sh      = b[SHW-1:0];
        sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        shl     = {1'b0, a} << sh;
        shr     = {a, 1'b0} >> sh;
        asr     = $signed({a, 1'b0}) >>> sh;
        alu_m   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = !is_legal_op(op);
        case (op)
            OP_ADD: begin
                alu_m = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_m = diff[WIDTH-1:0];
                alu_c = diff[WIDTH];
                alu_v = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_NOT: alu_m = ~a;
            OP_AND: alu_m = a & b;
            OP_OR:  alu_m = a | b;
            OP_XOR: alu_m = a ^ b;
            OP_SHL: begin
                alu_m = shl[WIDTH-1:0];
                alu_c = shl[WIDTH];
            end
            OP_SHR: begin
                alu_m = shr[WIDTH:1];
                alu_c = shr[0];
            end
            OP_ASR: begin
                alu_m = asr[WIDTH:1];
                alu_c = asr[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        m_d         = m_q;
        m_hi_d      = m_hi_q;
        flags_d     = flags_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d = MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        m_d         = alu_m;
                        m_hi_d      = '0;
                        flags_d     = {alu_m[MSB], ~|alu_m, alu_v, alu_c};
                        err_d       = alu_err;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    out_valid_d = 1'b1;
                    m_d         = mul_product[WIDTH-1:0];
                    m_hi_d      = mul_product[2*WIDTH-1:WIDTH];
                    flags_d     = {mul_product[MSB], ~|mul_product[WIDTH-1:0], 1'b0,
                                   |mul_product[2*WIDTH-1:WIDTH]};
                    err_d       = 1'b0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            m_q         <= '0;
            m_hi_q      <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            m_q         <= m_d;
            m_hi_q      <= m_hi_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign m         = m_q;
    assign m_hi      = m_hi_q;
    assign flag_n    = flags_q.n;
    assign flag_z    = flags_q.z;
    assign flag_v    = flags_q.v;
    assign flag_c    = flags_q.c;
    assign err       = err_q && out_valid_q;

endmodule
